// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS control FSM.
package mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_RTYPE_EX = 4'd2,
      S_RTYPE_WB = 4'd3,
      S_MEM_ADR  = 4'd4,
      S_MEM_RD   = 4'd5,
      S_MEM_WB   = 4'd6,
      S_MEM_WR   = 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9,
      S_IMM_EX   = 4'd10,
      S_IMM_WB   = 4'd11,
      S_TRAP     = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_SLTI  = 6'b001010;

   localparam logic [1:0] ALUB_REG    = 2'b00;
   localparam logic [1:0] ALUB_FOUR   = 2'b01;
   localparam logic [1:0] ALUB_IMM    = 2'b10;
   localparam logic [1:0] ALUB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;
   localparam logic [1:0] PCSRC_EXC    = 2'b11;

   // Logical immediates take a zero-extended operand.
   function automatic logic is_zero_ext(input logic [5:0] op);
      return (op == OP_ANDI) || (op == OP_ORI);
   endfunction

endpackage

// File: rtl/mc_retire_counter.sv
// Retired-instruction counter; wraps modulo 2^CNT_W, synchronous reset.
module mc_retire_counter #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             retire,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (reset)       count <= '0;
      else if (retire) count <= count + CNT_W'(1);
   end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Optional build macro ILLEGAL_TRAP_EN: unknown opcodes trap instead of acting as NOPs.
module multicycle_control
   import mc_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             i_or_d,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             mem_to_reg,
   output logic             reg_write,
   output logic             reg_dst,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic             alu_op1,
   output logic             alu_op0,
   output logic             opcode_gate,
   output logic             zero_ext,
   output logic [1:0]       pc_source,
`ifdef ILLEGAL_TRAP_EN
   output logic             illegal_instr,
`endif
   output logic [CNT_W-1:0] instr_count
);

   state_t state;
   state_t state_nxt;
   logic   retire;

   always_ff @(posedge clk) begin
      if (reset) state <= S_FETCH;
      else       state <= state_nxt;
   end

   // Moore decode plus mem_ready gating; everything is held at 0 during reset.
   always_comb begin
      state_nxt     = state;
      retire        = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = ALUB_REG;
      alu_op1       = 1'b0;
      alu_op0       = 1'b0;
      opcode_gate   = 1'b0;
      zero_ext      = 1'b0;
      pc_source     = PCSRC_ALU;
`ifdef ILLEGAL_TRAP_EN
      illegal_instr = 1'b0;
`endif
      if (!reset) begin
         case (state)
            S_FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = ALUB_FOUR;
               if (mem_ready) begin
                  ir_write  = 1'b1;
                  pc_write  = 1'b1;
                  state_nxt = S_DECODE;
               end
            end
            S_DECODE: begin
               alu_src_b = ALUB_IMM_SH;
               case (opcode)
                  OP_RTYPE:                         state_nxt = S_RTYPE_EX;
                  OP_LW, OP_SW:                     state_nxt = S_MEM_ADR;
                  OP_BEQ:                           state_nxt = S_BRANCH;
                  OP_J:                             state_nxt = S_JUMP;
                  OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_nxt = S_IMM_EX;
                  default: begin
`ifdef ILLEGAL_TRAP_EN
                     state_nxt = S_TRAP;
`else
                     state_nxt = S_FETCH;
                     retire    = 1'b1;
`endif
                  end
               endcase
            end
            S_RTYPE_EX: begin
               alu_src_a = 1'b1;
               alu_op1   = 1'b1;
               state_nxt = S_RTYPE_WB;
            end
            S_RTYPE_WB: begin
               reg_write = 1'b1;
               reg_dst   = 1'b1;
               retire    = 1'b1;
               state_nxt = S_FETCH;
            end
            S_MEM_ADR: begin
               alu_src_a = 1'b1;
               alu_src_b = ALUB_IMM;
               state_nxt = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
               mem_read = 1'b1;
               i_or_d   = 1'b1;
               if (mem_ready) state_nxt = S_MEM_WB;
            end
            S_MEM_WB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
               retire     = 1'b1;
               state_nxt  = S_FETCH;
            end
            S_MEM_WR: begin
               mem_write = 1'b1;
               i_or_d    = 1'b1;
               if (mem_ready) begin
                  retire    = 1'b1;
                  state_nxt = S_FETCH;
               end
            end
            S_BRANCH: begin
               alu_src_a     = 1'b1;
               alu_op0       = 1'b1;
               pc_write_cond = 1'b1;
               pc_source     = PCSRC_ALUOUT;
               retire        = 1'b1;
               state_nxt     = S_FETCH;
            end
            S_JUMP: begin
               pc_write  = 1'b1;
               pc_source = PCSRC_JUMP;
               retire    = 1'b1;
               state_nxt = S_FETCH;
            end
            S_IMM_EX: begin
               alu_src_a   = 1'b1;
               alu_src_b   = ALUB_IMM;
               opcode_gate = 1'b1;
               zero_ext    = is_zero_ext(opcode);
               state_nxt   = S_IMM_WB;
            end
            S_IMM_WB: begin
               reg_write   = 1'b1;
               opcode_gate = 1'b1;
               zero_ext    = is_zero_ext(opcode);
               retire      = 1'b1;
               state_nxt   = S_FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: begin
               pc_write      = 1'b1;
               pc_source     = PCSRC_EXC;
               illegal_instr = 1'b1;
               state_nxt     = S_FETCH;
            end
`endif
            default: state_nxt = S_FETCH;
         endcase
      end
   end

   mc_retire_counter #(.CNT_W(CNT_W)) u_retire_counter (
      .clk    (clk),
      .reset  (reset),
      .retire (retire),
      .count  (instr_count)
   );

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction expectation queues built from opcode class and stall plan.
module tb_multicycle_control;

   localparam int unsigned CNT_W = 32;
`ifdef ILLEGAL_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   localparam int PH_FETCH = 0, PH_DECODE = 1, PH_REX = 2, PH_RWB = 3, PH_MADR = 4, PH_MRD = 5,
                  PH_MWB = 6, PH_MWR = 7, PH_BR = 8, PH_J = 9, PH_IEX = 10, PH_IWB = 11, PH_TRAP = 12;
   localparam int C_RT = 0, C_LW = 1, C_SW = 2, C_BEQ = 3, C_J = 4, C_IMM = 5, C_UNK = 6;

   typedef struct packed {
      logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rdst, srca;
      logic [1:0] srcb;
      logic       aop1, aop0, gate, zext;
      logic [1:0] psrc;
      logic       ill;
   } ctl_t;

   logic             clk, reset, mem_ready;
   logic [5:0]       opcode;
   logic             pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic             mem_to_reg, reg_write, reg_dst, alu_src_a, alu_op1, alu_op0;
   logic             opcode_gate, zero_ext;
   logic [1:0]       alu_src_b, pc_source;
   logic [CNT_W-1:0] instr_count;
`ifdef ILLEGAL_TRAP_EN
   logic             illegal_instr;
`endif

   multicycle_control #(.CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_write(reg_write), .reg_dst(reg_dst),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op1(alu_op1), .alu_op0(alu_op0),
      .opcode_gate(opcode_gate), .zero_ext(zero_ext), .pc_source(pc_source),
`ifdef ILLEGAL_TRAP_EN
      .illegal_instr(illegal_instr),
`endif
      .instr_count(instr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   ctl_t obs;
   always_comb begin
      obs      = '0;
      obs.pcw  = pc_write;   obs.pcwc = pc_write_cond; obs.iord = i_or_d;
      obs.mrd  = mem_read;   obs.mwr  = mem_write;     obs.irw  = ir_write;
      obs.m2r  = mem_to_reg; obs.rw   = reg_write;     obs.rdst = reg_dst;
      obs.srca = alu_src_a;  obs.srcb = alu_src_b;     obs.aop1 = alu_op1;
      obs.aop0 = alu_op0;    obs.gate = opcode_gate;   obs.zext = zero_ext;
      obs.psrc = pc_source;
`ifdef ILLEGAL_TRAP_EN
      obs.ill  = illegal_instr;
`endif
   end

   int               tests = 0;
   int               failures = 0;
   logic [CNT_W-1:0] cnt_model;
   logic [5:0]       last_op;
   ctl_t             eq_ctl[$];
   logic             eq_mr[$];
   logic [5:0]       eq_op[$];
   logic [CNT_W-1:0] eq_cnt[$];
   ctl_t             oq_ctl[$];
   logic [CNT_W-1:0] oq_cnt[$];

   function automatic int cls(input logic [5:0] op);
      case (op)
         6'h00:                      return C_RT;
         6'h23:                      return C_LW;
         6'h2b:                      return C_SW;
         6'h04:                      return C_BEQ;
         6'h02:                      return C_J;
         6'h08, 6'h0c, 6'h0d, 6'h0a: return C_IMM;
         default:                    return C_UNK;
      endcase
   endfunction

   // Control word the datapath needs in each step of an instruction.
   function automatic ctl_t exp_of(input int ph, input logic [5:0] op, input logic rdy);
      ctl_t c = '0;
      case (ph)
         PH_FETCH:  begin c.mrd = 1; c.srcb = 2'b01; c.irw = rdy; c.pcw = rdy; end
         PH_DECODE: c.srcb = 2'b11;
         PH_REX:    begin c.srca = 1; c.srcb = 2'b00; c.aop1 = 1; end
         PH_RWB:    begin c.rw = 1; c.rdst = 1; end
         PH_MADR:   begin c.srca = 1; c.srcb = 2'b10; end
         PH_MRD:    begin c.mrd = 1; c.iord = 1; end
         PH_MWB:    begin c.rw = 1; c.m2r = 1; end
         PH_MWR:    begin c.mwr = 1; c.iord = 1; end
         PH_BR:     begin c.srca = 1; c.aop0 = 1; c.pcwc = 1; c.psrc = 2'b01; end
         PH_J:      begin c.pcw = 1; c.psrc = 2'b10; end
         PH_IEX:    begin c.srca = 1; c.srcb = 2'b10; c.gate = 1; c.zext = (op == 6'h0c || op == 6'h0d); end
         PH_IWB:    begin c.rw = 1; c.gate = 1; c.zext = (op == 6'h0c || op == 6'h0d); end
         PH_TRAP:   begin c.pcw = 1; c.psrc = 2'b11; c.ill = 1; end
         default:   c = '0;
      endcase
      return c;
   endfunction

   task automatic push(input ctl_t c, input logic mr, input logic [5:0] op, input bit ret);
      eq_ctl.push_back(c); eq_mr.push_back(mr); eq_op.push_back(op); eq_cnt.push_back(cnt_model);
      if (ret) cnt_model = cnt_model + 1;
   endtask

   // Expand one instruction into per-cycle expectations; fetch still sees the previous opcode in IR.
   task automatic add_instr(input logic [5:0] op, input int fs, input int ms);
      int k = cls(op);
      for (int i = 0; i < fs; i++) push(exp_of(PH_FETCH, last_op, 0), 1'b0, last_op, 0);
      push(exp_of(PH_FETCH, last_op, 1), 1'b1, last_op, 0);
      push(exp_of(PH_DECODE, op, 0), 1'($urandom_range(0, 1)), op, (k == C_UNK) && !TRAP_EN);
      case (k)
         C_RT: begin
            push(exp_of(PH_REX, op, 0), 1'($urandom_range(0, 1)), op, 0);
            push(exp_of(PH_RWB, op, 0), 1'($urandom_range(0, 1)), op, 1);
         end
         C_LW: begin
            push(exp_of(PH_MADR, op, 0), 1'($urandom_range(0, 1)), op, 0);
            for (int i = 0; i < ms; i++) push(exp_of(PH_MRD, op, 0), 1'b0, op, 0);
            push(exp_of(PH_MRD, op, 0), 1'b1, op, 0);
            push(exp_of(PH_MWB, op, 0), 1'($urandom_range(0, 1)), op, 1);
         end
         C_SW: begin
            push(exp_of(PH_MADR, op, 0), 1'($urandom_range(0, 1)), op, 0);
            for (int i = 0; i < ms; i++) push(exp_of(PH_MWR, op, 0), 1'b0, op, 0);
            push(exp_of(PH_MWR, op, 0), 1'b1, op, 1);
         end
         C_BEQ: push(exp_of(PH_BR, op, 0), 1'($urandom_range(0, 1)), op, 1);
         C_J:   push(exp_of(PH_J, op, 0), 1'($urandom_range(0, 1)), op, 1);
         C_IMM: begin
            push(exp_of(PH_IEX, op, 0), 1'($urandom_range(0, 1)), op, 0);
            push(exp_of(PH_IWB, op, 0), 1'($urandom_range(0, 1)), op, 1);
         end
         default: if (TRAP_EN) push(exp_of(PH_TRAP, op, 0), 1'($urandom_range(0, 1)), op, 0);
      endcase
      last_op = op;
   endtask

   task automatic clear_q();
      eq_ctl.delete(); eq_mr.delete(); eq_op.delete(); eq_cnt.delete();
      oq_ctl.delete(); oq_cnt.delete();
   endtask

   // Drive the planned inputs one cycle per entry and record what the DUT shows.
   task automatic run_queue();
      for (int i = 0; i < eq_ctl.size(); i++) begin
         @(negedge clk);
         reset = 1'b0; mem_ready = eq_mr[i]; opcode = eq_op[i];
         #1;
         oq_ctl.push_back(obs);
         oq_cnt.push_back(instr_count);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; mem_ready = 1'b1; opcode = 6'h0d;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         tests++; if (obs !== '0) begin failures++; $display("FAIL reset_outputs cyc %0d: got %b want 0", i, obs); end
         tests++; if (instr_count !== '0) begin failures++; $display("FAIL reset_count cyc %0d: got %0d want 0", i, instr_count); end
      end
      cnt_model = '0; last_op = 6'h0d;
      clear_q(); add_instr(6'h02, 0, 0); run_queue();
      for (int i = 0; i < eq_ctl.size(); i++) begin
         tests++; if (oq_ctl[i] !== eq_ctl[i]) begin failures++; $display("FAIL after_reset ctl cyc %0d: got %b want %b", i, oq_ctl[i], eq_ctl[i]); end
         tests++; if (oq_cnt[i] !== eq_cnt[i]) begin failures++; $display("FAIL after_reset cnt cyc %0d: got %0d want %0d", i, oq_cnt[i], eq_cnt[i]); end
      end
   endtask

   task automatic test_directed();
      clear_q();
      add_instr(6'h00, 0, 0);   // R-type
      add_instr(6'h23, 1, 2);   // lw, MEM_RD stalls twice
      add_instr(6'h0d, 0, 0);   // ori
      add_instr(6'h04, 0, 0);   // beq
      add_instr(6'h02, 0, 0);   // j
      add_instr(6'h2b, 0, 1);   // sw
      add_instr(6'h3f, 0, 0);   // unknown opcode
      add_instr(6'h08, 2, 0);   // addi
      run_queue();
      for (int i = 0; i < eq_ctl.size(); i++) begin
         tests++; if (oq_ctl[i] !== eq_ctl[i]) begin failures++; $display("FAIL directed ctl cyc %0d: got %b want %b", i, oq_ctl[i], eq_ctl[i]); end
         tests++; if (oq_cnt[i] !== eq_cnt[i]) begin failures++; $display("FAIL directed cnt cyc %0d: got %0d want %0d", i, oq_cnt[i], eq_cnt[i]); end
      end
   endtask

   task automatic test_reset_mid_write();
      clear_q();
      push(exp_of(PH_FETCH, last_op, 1), 1'b1, last_op, 0);
      push(exp_of(PH_DECODE, 6'h2b, 0), 1'b1, 6'h2b, 0);
      push(exp_of(PH_MADR, 6'h2b, 0), 1'b1, 6'h2b, 0);
      push(exp_of(PH_MWR, 6'h2b, 0), 1'b0, 6'h2b, 0);
      push(exp_of(PH_MWR, 6'h2b, 0), 1'b0, 6'h2b, 0);
      run_queue();
      for (int i = 0; i < eq_ctl.size(); i++) begin
         tests++; if (oq_ctl[i] !== eq_ctl[i]) begin failures++; $display("FAIL midreset ctl cyc %0d: got %b want %b", i, oq_ctl[i], eq_ctl[i]); end
      end
      @(negedge clk);
      reset = 1'b1; mem_ready = 1'b1; #1;
      tests++; if (obs !== '0) begin failures++; $display("FAIL midreset_outputs: got %b want 0", obs); end
      cnt_model = '0;   // reset also clears the count
      last_op = 6'h2b;
      clear_q(); add_instr(6'h00, 0, 0); run_queue();
      for (int i = 0; i < eq_ctl.size(); i++) begin
         tests++; if (oq_ctl[i] !== eq_ctl[i]) begin failures++; $display("FAIL post_midreset ctl cyc %0d: got %b want %b", i, oq_ctl[i], eq_ctl[i]); end
         tests++; if (oq_cnt[i] !== eq_cnt[i]) begin failures++; $display("FAIL post_midreset cnt cyc %0d: got %0d want %0d", i, oq_cnt[i], eq_cnt[i]); end
      end
   endtask

   task automatic test_random();
      logic [5:0] ops [9] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h08, 6'h0c, 6'h0d, 6'h0a};
      logic [5:0] op;
      clear_q();
      for (int n = 0; n < 60; n++) begin
         int pick = $urandom_range(0, 9);
         op = (pick == 9) ? 6'($urandom) : ops[pick];
         add_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
      end
      run_queue();
      for (int i = 0; i < eq_ctl.size(); i++) begin
         tests++; if (oq_ctl[i] !== eq_ctl[i]) begin failures++; $display("FAIL random ctl cyc %0d op %h: got %b want %b", i, eq_op[i], oq_ctl[i], eq_ctl[i]); end
         tests++; if (oq_cnt[i] !== eq_cnt[i]) begin failures++; $display("FAIL random cnt cyc %0d: got %0d want %0d", i, oq_cnt[i], eq_cnt[i]); end
      end
      @(negedge clk); mem_ready = 1'b0; #1;
      tests++; if (instr_count !== cnt_model) begin failures++; $display("FAIL final_count: got %0d want %0d", instr_count, cnt_model); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_reset_mid_write();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
